hazard_monitor: RTL
===================

Name: hazard_monitor

Overview:
- Receive-side checker for the static-hazard stimulus benches. It watches one circuit output that should hold a steady level across an input transition.
- It oversamples that output on a fast clock and classifies each departure from the expected level. A short departure is a glitch (static-1 or static-0 hazard); a long departure is a functional fault.
- Sits between a hazard-prone combinational block (e.g. the corrected/uncorrected FB circuit) and the bench or on-chip status logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on sig_in (minimum 2).
- MAX_GLITCH, 4, longest deviation, in cycles, still classed as a glitch. Must be less than 2^WIDTH_W - 1.
- CNT_W, 8, width of the glitch counter.
- WIDTH_W, 4, width of the deviation-width field.

Ports:
- clk  in  1  sampling clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  monitoring enable.
- exp_level  in  1  level sig_in is expected to hold steady.
- clr  in  1  synchronous clear of the counter and status; single-cycle pulse.
- sig_in  in  1  asynchronous signal under observation.
- glitch_pulse  out  1  one-cycle strobe per glitch detected.
- glitch_cnt  out  CNT_W  number of glitches detected; saturates at all-ones.
- last_width  out  WIDTH_W  width in cycles of the most recent glitch.
- hz_type  out  1  type of last glitch: 1 = static-1 (dip while expecting 1), 0 = static-0.
- fault  out  1  sticky; a deviation exceeded MAX_GLITCH cycles.

Behaviour:
- Reset (rst_n=0, async): all outputs 0, synchronizer flops 0, FSM in IDLE, width counter wcnt=0.
- Synchronizer: s = sig_in delayed by SYNC_STAGES clk edges. All decisions below use s only.
- FSM states and transitions:
  - IDLE: entered when en=0, from any state; a deviation in progress is discarded. When en=1, go to ARM.
  - ARM: wait for s==exp_level, then go to STEADY. A deviation present at arm time is not counted.
  - STEADY: when s!=exp_level, go to DEVIATE with wcnt=1.
  - DEVIATE: while s!=exp_level, wcnt increments.
    - On s==exp_level with wcnt<=MAX_GLITCH, record a glitch and go to STEADY.
    - When wcnt would reach MAX_GLITCH+1, set fault=1 and go to FAULT.
  - FAULT: no further classification. Leave only via clr (to ARM) or en=0 (to IDLE).
- Recording a glitch, registered on the edge where the return is seen:
  - glitch_pulse=1 for exactly one cycle;
  - glitch_cnt increments, saturating at 2^CNT_W-1;
  - last_width=wcnt;
  - hz_type=exp_level.
- Latency: glitch_pulse rises SYNC_STAGES+1 edges after sig_in returns to exp_level.
- Back-to-back glitches separated by a single steady sample are each counted.
- exp_level changes while en=1: go to ARM; any deviation in progress is discarded with no count and no fault.
- clr=1:
  - glitch_cnt, last_width, hz_type and fault are cleared on the next edge;
  - FSM goes to ARM if en=1, otherwise IDLE.
  - clr beats a same-cycle glitch record: the count ends at 0 and no glitch_pulse is issued.
- Outputs other than glitch_pulse hold their values in IDLE.

Decomposition:
- Package hazard_mon_pkg:
  - state enum {IDLE, ARM, STEADY, DEVIATE, FAULT};
  - localparam CNT_MAX;
  - HZ_STATIC1=1, HZ_STATIC0=0.
- Sub-module sync_nff (parameter STAGES, async active-low reset to 0) for the sig_in synchronizer.
- FSM, wcnt, counter and status registers live in hazard_monitor.

Test Plan:
- Static-1 hazard: en=1, exp_level=1, sig_in=1 for 10 cycles, then 0 for 2 cycles, then 1. Expect glitch_pulse for one cycle exactly SYNC_STAGES+1 edges after sig_in returns; glitch_cnt=1, last_width=2, hz_type=1, fault=0.
- Static-0 hazard: exp_level=0, sig_in high for 1 cycle. Expect glitch_cnt=1, last_width=1, hz_type=0.
- Fault: exp_level=1, sig_in low for 5 cycles (MAX_GLITCH=4). Expect fault=1 and no glitch_pulse. A later 1-cycle dip is not counted; after clr, fault=0 and a 1-cycle dip gives glitch_cnt=1.
- Saturation and clr priority: CNT_W=2, 5 one-cycle dips, expect glitch_cnt=3. Then clr coincident with a glitch record: expect glitch_cnt=0 and no pulse.
- Mode changes: exp_level toggles mid-deviation, expect no count and no fault. en drops mid-deviation and returns with sig_in low, expect ARM to wait and no count.
- Async reset: assert rst_n=0 mid-DEVIATE, off a clock edge. Expect all outputs 0 immediately, then a normal glitch count after release.

Source files
------------

// File: rtl/hazard_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_mon_pkg
// Brief  : Shared FSM encoding and constants for the static-hazard monitor.
// Rev    : 1.0
// ============================================================================
package hazard_mon_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    STEADY  = 3'd2,
    DEVIATE = 3'd3,
    FAULT   = 3'd4
  } state_t;

  // All-ones saturation limit; users truncate it to their counter width (<= 32).
  localparam int unsigned CNT_MAX = 32'hFFFF_FFFF;

  localparam logic HZ_STATIC1 = 1'b1;
  localparam logic HZ_STATIC0 = 1'b0;

endpackage
`default_nettype wire

// File: rtl/hazard_monitor_sync_nff.sv
`default_nettype none
// ============================================================================
// Module : sync_nff
// Brief  : STAGES-deep flop chain bringing an asynchronous bit into clk.
// Rev    : 1.0
// ============================================================================
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= {r_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/hazard_monitor.sv
`default_nettype none
// ============================================================================
// Module : hazard_monitor
// Brief  : Oversamples a nominally steady signal, classifying glitches/faults.
// Rev    : 1.0
// ============================================================================
module hazard_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_GLITCH  = 4,
  parameter int CNT_W       = 8,
  parameter int WIDTH_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               exp_level,
  input  logic               clr,
  input  logic               sig_in,
  output logic               glitch_pulse,
  output logic [CNT_W-1:0]   glitch_cnt,
  output logic [WIDTH_W-1:0] last_width,
  output logic               hz_type,
  output logic               fault
);

  import hazard_mon_pkg::*;

  localparam logic [CNT_W-1:0]   c_CNT_MAX    = CNT_W'(CNT_MAX);
  localparam logic [WIDTH_W-1:0] c_MAX_GLITCH = WIDTH_W'(MAX_GLITCH);

  logic w_s;
  logic w_dev;
  logic w_exp_chg;

  state_t             r_state;
  logic [WIDTH_W-1:0] r_wcnt;
  logic               r_exp_prev;
  logic               r_pulse;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH_W-1:0] r_width;
  logic               r_hz;
  logic               r_fault;

  sync_nff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (sig_in),
    .o_q   (w_s)
  );

  assign w_dev     = (w_s != exp_level);
  assign w_exp_chg = (exp_level != r_exp_prev);

  // Priority: clr, then disable, then expected-level change, then normal FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wcnt     <= '0;
      r_exp_prev <= 1'b0;
      r_pulse    <= 1'b0;
      r_cnt      <= '0;
      r_width    <= '0;
      r_hz       <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_pulse    <= 1'b0;
      r_exp_prev <= exp_level;
      if (clr) begin
        r_cnt   <= '0;
        r_width <= '0;
        r_hz    <= 1'b0;
        r_fault <= 1'b0;
        r_wcnt  <= '0;
        r_state <= en ? ARM : IDLE;
      end else if (!en) begin
        r_wcnt  <= '0;
        r_state <= IDLE;
      end else if (w_exp_chg && (r_state != FAULT)) begin
        r_wcnt  <= '0;
        r_state <= ARM;
      end else begin
        case (r_state)
          IDLE: r_state <= ARM;
          ARM: begin
            if (!w_dev) r_state <= STEADY;
          end
          STEADY: begin
            if (w_dev) begin
              r_wcnt  <= WIDTH_W'(1);
              r_state <= DEVIATE;
            end
          end
          DEVIATE: begin
            if (!w_dev) begin
              r_pulse <= 1'b1;
              if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + 1'b1;
              r_width <= r_wcnt;
              r_hz    <= exp_level ? HZ_STATIC1 : HZ_STATIC0;
              r_wcnt  <= '0;
              r_state <= STEADY;
            end else if (r_wcnt == c_MAX_GLITCH) begin
              r_fault <= 1'b1;
              r_wcnt  <= '0;
              r_state <= FAULT;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
          FAULT:   r_state <= FAULT;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign glitch_pulse = r_pulse;
  assign glitch_cnt   = r_cnt;
  assign last_width   = r_width;
  assign hz_type      = r_hz;
  assign fault        = r_fault;

endmodule
`default_nettype wire
